// File: rtl/vga_pattern_gen_if.sv
// Pixel-stream bundle for vga_pattern_gen: the pattern select going in,
// the timing counters, syncs, blanking and RGB332 pixel coming out.
interface vga_pattern_gen_if #(
  parameter int unsigned CNT_W = 10
);
  logic [1:0]       mode;
  logic             hsync;
  logic             vsync;
  logic [CNT_W-1:0] hc;
  logic [CNT_W-1:0] vc;
  logic             vidon;
  logic [2:0]       red;
  logic [2:0]       green;
  logic [1:0]       blue;
  logic             frame_start;

  modport master (
    input  mode,
    output hsync, vsync, hc, vc, vidon, red, green, blue, frame_start
  );

  modport slave (
    output mode,
    input  hsync, vsync, hc, vc, vidon, red, green, blue, frame_start
  );
endinterface

// File: rtl/vga_pattern_gen.sv
// VGA timing generator with four test patterns; all outputs are registered
// together with hc/vc so every output is a function of the hc/vc shown with it.
module vga_pattern_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned CLK_DIV  = 4,
  parameter bit          SYNC_POL = 1'b0,
  parameter int unsigned CNT_W    = 10
) (
  input logic               clk,
  input logic               clr,
  vga_pattern_gen_if.master vga
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(H_ACTIVE / 8 - 1);

  typedef enum logic [1:0] {
    MODE_STRIPES = 2'd0,
    MODE_BARS    = 2'd1,
    MODE_CHECKER = 2'd2,
    MODE_SCROLL  = 2'd3
  } mode_e;

  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] hc_q, hc_d, vc_q, vc_d, bar_px_q, bar_px_d;
  logic [2:0]       bar_q, bar_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;
  mode_e            mode_q, mode_d;
  logic             hsync_q, hsync_d, vsync_q, vsync_d, vidon_q, vidon_d;
  logic             frame_start_q, frame_start_d;
  logic [2:0]       red_q, red_d, green_q, green_d;
  logic [1:0]       blue_q, blue_d;
  logic             pe, hc_wrap, frame_wrap, stripe_bit;

  always_comb begin
    pe            = (div_q == DIV_LAST);
    div_d         = pe ? '0 : div_q + 1'b1;
    hc_wrap       = (hc_q == H_LAST);
    frame_wrap    = hc_wrap && (vc_q == V_LAST);
    hc_d          = hc_q;
    vc_d          = vc_q;
    bar_px_d      = bar_px_q;
    bar_d         = bar_q;
    frame_cnt_d   = frame_cnt_q;
    mode_d        = mode_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    vidon_d       = vidon_q;
    red_d         = red_q;
    green_d       = green_q;
    blue_d        = blue_q;
    frame_start_d = 1'b0;
    stripe_bit    = 1'b0;

    if (pe) begin
      hc_d = hc_wrap ? '0 : hc_q + 1'b1;
      if (hc_wrap) begin
        vc_d     = (vc_q == V_LAST) ? '0 : vc_q + 1'b1;
        bar_px_d = '0;
        bar_d    = '0;
      end else if (bar_px_q == BAR_LAST) begin
        bar_px_d = '0;
        if (bar_q != 3'd7) bar_d = bar_q + 1'b1;
      end else begin
        bar_px_d = bar_px_q + 1'b1;
      end

      // Mode and scroll offset latch here so the new frame's first pixel uses them.
      if (frame_wrap) begin
        frame_cnt_d   = frame_cnt_q + 1'b1;
        mode_d        = mode_e'(vga.mode);
        frame_start_d = 1'b1;
      end

      hsync_d = ((hc_d >= HS_START) && (hc_d < HS_END)) ? SYNC_POL : ~SYNC_POL;
      vsync_d = ((vc_d >= VS_START) && (vc_d < VS_END)) ? SYNC_POL : ~SYNC_POL;
      vidon_d = (hc_d < H_ACT_C) && (vc_d < V_ACT_C);

      // Only the low five bits of vc + frame_cnt decide bit 4 of the truncated sum.
      if (mode_d == MODE_SCROLL) stripe_bit = 5'(vc_d[4:0] + frame_cnt_d[4:0]) >= 5'd16;
      else                       stripe_bit = vc_d[4];

      red_d   = '0;
      green_d = '0;
      blue_d  = '0;
      if (vidon_d) begin
        case (mode_d)
          MODE_BARS: begin
            red_d   = {3{bar_d[2]}};
            green_d = {3{bar_d[1]}};
            blue_d  = {2{bar_d[0]}};
          end
          MODE_CHECKER: begin
            red_d   = {3{hc_d[5] ^ vc_d[5]}};
            green_d = {3{hc_d[5] ^ vc_d[5]}};
            blue_d  = {2{hc_d[5] ^ vc_d[5]}};
          end
          default: begin
            red_d   = {3{stripe_bit}};
            green_d = {3{~stripe_bit}};
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      div_q         <= '0;
      hc_q          <= '0;
      vc_q          <= '0;
      bar_px_q      <= '0;
      bar_q         <= '0;
      frame_cnt_q   <= '0;
      mode_q        <= MODE_STRIPES;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      vidon_q       <= 1'b0;
      red_q         <= '0;
      green_q       <= '0;
      blue_q        <= '0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      bar_px_q      <= bar_px_d;
      bar_q         <= bar_d;
      frame_cnt_q   <= frame_cnt_d;
      mode_q        <= mode_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      vidon_q       <= vidon_d;
      red_q         <= red_d;
      green_q       <= green_d;
      blue_q        <= blue_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga.hc          = hc_q;
  assign vga.vc          = vc_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.vidon       = vidon_q;
  assign vga.red         = red_q;
  assign vga.green       = green_q;
  assign vga.blue        = blue_q;
  assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen: a small-timing instance (CLK_DIV=2, active-low
// syncs) driven from a vector table, and a tiny CLK_DIV=1 active-high instance.
module tb_vga_pattern_gen;
  localparam int unsigned CW = 10;
  localparam int A_FRAME_CLKS = 72 * 48 * 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clr_a = 1'b1;
  logic clr_b = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  vga_pattern_gen_if #(.CNT_W(CW)) va ();
  vga_pattern_gen_if #(.CNT_W(CW)) vb ();

  vga_pattern_gen #(
    .H_ACTIVE(64), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(40), .V_FP(2), .V_SYNC(2), .V_BP(4),
    .CLK_DIV(2), .SYNC_POL(1'b0), .CNT_W(CW)
  ) dut_a (.clk(clk), .clr(clr_a), .vga(va));

  vga_pattern_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
    .CLK_DIV(1), .SYNC_POL(1'b1), .CNT_W(CW)
  ) dut_b (.clk(clk), .clr(clr_b), .vga(vb));

  typedef struct {
    logic [1:0]    drv_mode;
    logic [CW-1:0] hc;
    logic [CW-1:0] vc;
    logic          hs;
    logic          vs;
    logic          von;
    logic [7:0]    rgb;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int m, input int h, input int v, input int hs, input int vs,
                     input int von, input int r, input int g, input int b);
    vec_t e;
    e.drv_mode = 2'(m);
    e.hc       = CW'(h);
    e.vc       = CW'(v);
    e.hs       = 1'(hs);
    e.vs       = 1'(vs);
    e.von      = 1'(von);
    e.rgb      = {3'(r), 3'(g), 2'(b)};
    vecs.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic wait_pos(input bit sel_b, input logic [CW-1:0] h, input logic [CW-1:0] v,
                          input int limit, input string name, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < limit && !ok; n++) begin
      @(negedge clk);
      if (sel_b) ok = (vb.hc == h) && (vb.vc == v);
      else       ok = (va.hc == h) && (va.vc == v);
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: position (%0d,%0d) not reached, required within %0d clks", name, h, v, limit);
    end
  endtask

  task automatic wait_fs(input bit sel_b, input int limit, input string name, output int cnt);
    bit seen = 1'b0;
    cnt = 0;
    while (!seen && cnt < limit) begin
      @(negedge clk);
      cnt++;
      seen = sel_b ? vb.frame_start : va.frame_start;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: frame_start not seen, required within %0d clks", name, limit);
    end
  endtask

  task automatic run_a();
    bit ok;
    int cnt;
    va.mode = 2'd0;
    clr_a   = 1'b1;
    repeat (3) @(negedge clk);
    check("a_rst_hc", va.hc, 0);
    check("a_rst_vc", va.vc, 0);
    check("a_rst_hsync", va.hsync, 1);
    check("a_rst_vsync", va.vsync, 1);
    check("a_rst_vidon", va.vidon, 0);
    check("a_rst_rgb", {va.red, va.green, va.blue}, 0);
    check("a_rst_fs", va.frame_start, 0);

    clr_a = 1'b0;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (va.hc != 1 && cnt < 10);
    check("a_first_pe_latency", cnt, 2);
    @(negedge clk);
    check("a_hold_between_pe", va.hc, 1);
    @(negedge clk);
    check("a_second_pe", va.hc, 2);

    // Frame 0: stripes (mode register cleared by reset); mode 2 requested mid-frame.
    add(0,  5,  0, 1, 1, 1, 0, 7, 0);
    add(0, 63, 15, 1, 1, 1, 0, 7, 0);
    add(0, 64, 15, 1, 1, 0, 0, 0, 0);
    add(0, 65, 15, 1, 1, 0, 0, 0, 0);
    add(0, 66, 15, 0, 1, 0, 0, 0, 0);
    add(0, 69, 15, 0, 1, 0, 0, 0, 0);
    add(0, 70, 15, 1, 1, 0, 0, 0, 0);
    add(0, 10, 16, 1, 1, 1, 7, 0, 0);
    add(2, 10, 20, 1, 1, 1, 7, 0, 0);
    add(2, 40, 33, 1, 1, 1, 0, 7, 0);
    add(2, 10, 40, 1, 1, 0, 0, 0, 0);
    add(2, 10, 41, 1, 1, 0, 0, 0, 0);
    add(2, 10, 42, 1, 0, 0, 0, 0, 0);
    add(2, 10, 43, 1, 0, 0, 0, 0, 0);
    add(2, 67, 43, 0, 0, 0, 0, 0, 0);
    add(2, 10, 44, 1, 1, 0, 0, 0, 0);
    // Frame 1: checkerboard; bars requested for frame 2.
    add(2,  0,  0, 1, 1, 1, 0, 0, 0);
    add(1, 32,  0, 1, 1, 1, 7, 7, 3);
    add(1, 31,  5, 1, 1, 1, 0, 0, 0);
    add(1, 10, 33, 1, 1, 1, 7, 7, 3);
    add(1, 40, 33, 1, 1, 1, 0, 0, 0);
    // Frame 2: colour bars, 8 pixels each; scrolling requested for frame 3.
    add(1,  0,  0, 1, 1, 1, 0, 0, 0);
    add(1,  7,  0, 1, 1, 1, 0, 0, 0);
    add(1,  8,  0, 1, 1, 1, 0, 0, 3);
    add(1, 16,  0, 1, 1, 1, 0, 7, 0);
    add(1, 24,  0, 1, 1, 1, 0, 7, 3);
    add(1, 32,  0, 1, 1, 1, 7, 0, 0);
    add(1, 47,  0, 1, 1, 1, 7, 0, 3);
    add(1, 48,  0, 1, 1, 1, 7, 7, 0);
    add(1, 63,  0, 1, 1, 1, 7, 7, 3);
    add(1, 64,  0, 1, 1, 0, 0, 0, 0);
    add(1,  3,  1, 1, 1, 1, 0, 0, 0);
    add(1, 12,  1, 1, 1, 1, 0, 0, 3);
    add(3, 60, 39, 1, 1, 1, 7, 7, 3);
    // Frames 3..5: scrolling stripes with frame_cnt 3, 4, 5.
    add(3,  0,  0, 1, 1, 1, 0, 7, 0);
    add(3,  5, 12, 1, 1, 1, 0, 7, 0);
    add(3,  5, 13, 1, 1, 1, 7, 0, 0);
    add(3,  5, 11, 1, 1, 1, 0, 7, 0);
    add(3,  5, 12, 1, 1, 1, 7, 0, 0);
    add(3,  5, 10, 1, 1, 1, 0, 7, 0);
    add(3,  5, 11, 1, 1, 1, 7, 0, 0);
    add(3,  5, 26, 1, 1, 1, 7, 0, 0);
    add(3,  5, 27, 1, 1, 1, 0, 7, 0);

    foreach (vecs[i]) begin
      va.mode = vecs[i].drv_mode;
      wait_pos(1'b0, vecs[i].hc, vecs[i].vc, 2 * A_FRAME_CLKS, $sformatf("row%0d_pos", i), ok);
      if (ok) begin
        check($sformatf("row%0d_hsync", i), va.hsync, vecs[i].hs);
        check($sformatf("row%0d_vsync", i), va.vsync, vecs[i].vs);
        check($sformatf("row%0d_vidon", i), va.vidon, vecs[i].von);
        check($sformatf("row%0d_rgb", i), {va.red, va.green, va.blue}, vecs[i].rgb);
      end
    end

    wait_fs(1'b0, 2 * A_FRAME_CLKS, "a_fs_first", cnt);
    check("a_fs_hc", va.hc, 0);
    check("a_fs_vc", va.vc, 0);
    @(negedge clk);
    check("a_fs_width", va.frame_start, 0);
    wait_fs(1'b0, 2 * A_FRAME_CLKS, "a_fs_second", cnt);
    check("a_frame_period", cnt + 1, A_FRAME_CLKS);

    // Reset mid-frame: takes effect on the next edge and clears the latched mode.
    wait_pos(1'b0, CW'(30), CW'(20), 2 * A_FRAME_CLKS, "a_midreset_pos", ok);
    va.mode = 2'd2;
    clr_a   = 1'b1;
    @(negedge clk);
    check("a_midrst_hc", va.hc, 0);
    check("a_midrst_vc", va.vc, 0);
    check("a_midrst_sync", {va.hsync, va.vsync}, 2'b11);
    check("a_midrst_vidon_rgb", {va.vidon, va.red, va.green, va.blue}, 0);
    clr_a = 1'b0;
    wait_pos(1'b0, CW'(32), CW'(0), 200, "a_postrst_pos", ok);
    if (ok) check("a_postrst_mode_cleared", {va.red, va.green, va.blue}, {3'd0, 3'd7, 2'd0});
  endtask

  task automatic run_b();
    bit ok;
    int cnt;
    int fc;
    logic stripe;
    vb.mode = 2'd3;
    clr_b   = 1'b1;
    repeat (3) @(negedge clk);
    check("b_rst_sync", {vb.hsync, vb.vsync}, 2'b00);
    check("b_rst_hc", vb.hc, 0);
    clr_b = 1'b0;
    @(negedge clk);
    check("b_first_pe", vb.hc, 1);
    @(negedge clk);
    check("b_every_clk", vb.hc, 2);
    wait_pos(1'b1, CW'(8), CW'(0), 20, "b_hc8_pos", ok);
    if (ok) begin
      check("b_hsync_before", vb.hsync, 0);
      @(negedge clk);
      check("b_hc9", vb.hc, 9);
      check("b_hsync_asserted", vb.hsync, 1);
    end

    // Frame k after reset runs scroll mode with frame_cnt = k mod 256.
    for (int k = 1; k <= 258; k++) begin
      wait_fs(1'b1, 200, $sformatf("b_fs%0d", k), cnt);
      wait_pos(1'b1, CW'(0), CW'(3), 100, $sformatf("b_pos%0d", k), ok);
      if (ok) begin
        fc = k % 256;
        stripe = (((3 + fc) % 1024) / 16) % 2 == 1;
        check($sformatf("b_scroll_f%0d", k), {vb.red, vb.green, vb.blue},
              stripe ? {3'd7, 3'd0, 2'd0} : {3'd0, 3'd7, 2'd0});
      end
    end
  endtask

  initial begin
    fork
      run_a();
      run_b();
    join
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_pattern_gen.md
VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameters H_FP, H_SYNC, H_BP, defaults 16, 96, 48, horizontal front porch, sync and back porch in pixels.
REQ-003 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 Parameters V_FP, V_SYNC, V_BP, defaults 10, 2, 33, vertical front porch, sync and back porch in lines.
REQ-005 Parameter CLK_DIV, default 4, clk cycles per pixel (>=1).
REQ-006 Parameter SYNC_POL, default 0, asserted sync level (0 = active-low).
REQ-007 Parameter CNT_W, default 10, width of hc/vc.
REQ-008 clk  input  1  system clock, the only clock.
REQ-009 clr  input  1  reset, synchronous, active-high.
REQ-010 mode  input  2  pattern select: 0 stripes, 1 colour bars, 2 checkerboard, 3 scrolling stripes.
REQ-011 hsync, vsync  output  1 each  sync outputs at polarity SYNC_POL.
REQ-012 hc, vc  output  CNT_W each  current pixel column and line.
REQ-013 vidon  output  1  high when hc<H_ACTIVE and vc<V_ACTIVE.
REQ-014 red, green  output  3 each; blue  output  2  RGB332 pixel.
REQ-015 frame_start  output  1  one-clk pulse on the pe cycle where hc and vc wrap to 0.

Function
REQ-016 Internal divider SHALL assert pixel enable pe for one clk every CLK_DIV clks; with CLK_DIV=1, pe is held high.
REQ-017 hc SHALL increment on pe and wrap from H_TOTAL-1 to 0, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
REQ-018 vc SHALL increment on pe only when hc wraps, and wrap from V_TOTAL-1 to 0, where V_TOTAL is defined likewise.
REQ-019 hsync SHALL be asserted iff H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC; vsync is defined likewise on vc.
REQ-020 hsync, vsync, vidon, red, green and blue SHALL be registered and aligned with hc and vc: each is a pure function of the hc/vc values presented in the same clk.
REQ-021 Active mode SHALL be sampled from the mode input only at frame wrap (hc=vc=0 transition), so a mode change never tears mid-frame.
REQ-022 When vidon=0, red, green and blue SHALL all be 0.
REQ-023 Mode 0: vc[4]=1 gives red=7, green=0, blue=0; vc[4]=0 gives red=0, green=7, blue=0.
REQ-024 Mode 1: a sequential bar counter SHALL divide the active line into 8 bars of H_ACTIVE/8 pixels, with bar index b = 0..7 from hc=0 and saturating at 7; output is red={3{b[2]}}, green={3{b[1]}}, blue={2{b[0]}}.
REQ-025 Mode 2: hc[5]^vc[5]=1 gives all-ones (white), otherwise black.
REQ-026 Mode 3: as mode 0, but using bit 4 of (vc + frame_cnt) truncated to CNT_W, where frame_cnt is an 8-bit counter that increments at each frame wrap and wraps 255->0.
REQ-027 Between pe cycles, all outputs SHALL hold their values.

Reset
REQ-028 While clr=1 at a clk edge: divider, hc, vc, bar counter, frame_cnt and the registered mode SHALL be set to 0; hsync and vsync deasserted (level ~SYNC_POL); vidon, RGB and frame_start set to 0.
REQ-029 Reset asserted mid-frame SHALL take effect on the next clk edge.
REQ-030 After clr is released, the first pe SHALL occur CLK_DIV clks later and move hc to 1.

Verification
REQ-031 Defaults, clr released, count clks between frame_start pulses -> 800*525*4 = 1,680,000.
REQ-032 Defaults -> hsync low exactly for hc 656..751; vsync low exactly for vc 490..491; vidon low at hc=640 and at vc=480.
REQ-033 Mode 1, line vc=0 -> RGB 0x00 at hc 0..79, blue=3 only at hc 80..159, …, all-ones at hc 560..639, 0 at hc 640..799.
REQ-034 Mode switched 0->2 mid-frame at vc=100 -> stripes persist until frame_start, checkerboard from the next frame's (0,0).
REQ-035 Mode 3 over 3 frames -> the stripe boundary seen at vc=16 in frame 0 appears at vc=15 in frame 1 and at vc=14 in frame 2; frame_cnt wraps 255->0 without glitch.
REQ-036 clr pulsed for 1 clk at hc=300, vc=200 -> next clk hc=vc=0, outputs at reset values; with CLK_DIV=1, hc advances every clk.
